icache_fetch: RTL

- Direct-mapped, read-only instruction cache that answers the CPU's PC-driven instruction fetch.
- CPU side: presents PC and READ; receives INSTRUCTION, or BUSYWAIT while a line is being filled.
- Memory side: issues block reads to the slow instruction memory and waits for a one-cycle MEM_VALID pulse carrying a 128-bit line.
- Sits between the CPU's fetch port and the byte-addressed 1024-entry instruction memory.

---
 rtl/icache_fetch.sv | 101 ++++++++++
 1 files changed

// File: rtl/icache_fetch.sv
// Direct-mapped, read-only instruction cache for the CPU fetch port.
// Lines are 16 bytes (4 words) and are refilled from a 128-bit block-read memory.
module icache_fetch #(
  parameter int unsigned ADDR_BITS = 10,
  parameter int unsigned NUM_LINES = 8
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [31:0]          PC,
  input  logic                 READ,
  output logic [31:0]          INSTRUCTION,
  output logic                 BUSYWAIT,
  output logic                 MEM_READ,
  output logic [ADDR_BITS-5:0] MEM_ADDRESS,
  input  logic [127:0]         MEM_READDATA,
  input  logic                 MEM_VALID,
  output logic [15:0]          HIT_COUNT,
  output logic [15:0]          MISS_COUNT
);

  localparam int unsigned INDEX_BITS = $clog2(NUM_LINES);
  localparam int unsigned TAG_BITS   = ADDR_BITS - 4 - INDEX_BITS;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t                    state_q;
  logic [NUM_LINES-1:0]      valid_q;
  logic [TAG_BITS-1:0]       tag_q  [NUM_LINES];
  logic [127:0]              data_q [NUM_LINES];
  logic [ADDR_BITS-5:0]      maddr_q;
  logic [15:0]               hit_cnt_q;
  logic [15:0]               miss_cnt_q;

  logic [INDEX_BITS-1:0]     pc_index;
  logic [TAG_BITS-1:0]       pc_tag;
  logic [1:0]                pc_offset;
  logic [INDEX_BITS-1:0]     fill_index;
  logic                      lookup;
  logic                      hit;
  logic                      miss;
  logic                      unused_pc_bits;

  assign pc_index   = PC[INDEX_BITS+3:4];
  assign pc_tag     = PC[ADDR_BITS-1:INDEX_BITS+4];
  assign pc_offset  = PC[3:2];
  assign fill_index = maddr_q[INDEX_BITS-1:0];
  assign unused_pc_bits = ^{PC[31:ADDR_BITS], PC[1:0]};

  // Lookups happen only in IDLE and never while RESET is held.
  assign lookup = !RESET && (state_q == IDLE) && READ;
  assign hit    = lookup && valid_q[pc_index] && (tag_q[pc_index] == pc_tag);
  assign miss   = lookup && !hit;

  always_comb begin
    INSTRUCTION = 32'h0;
    if (hit) begin
      INSTRUCTION = data_q[pc_index][32*pc_offset +: 32];
    end
  end

  assign BUSYWAIT    = (state_q == FETCH) || miss;
  assign MEM_READ    = (state_q == FETCH);
  assign MEM_ADDRESS = (state_q == FETCH) ? maddr_q : '0;
  assign HIT_COUNT   = hit_cnt_q;
  assign MISS_COUNT  = miss_cnt_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      maddr_q    <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hit && (hit_cnt_q != 16'hFFFF)) begin
            hit_cnt_q <= hit_cnt_q + 16'd1;
          end
          if (miss) begin
            maddr_q <= {pc_tag, pc_index};
            state_q <= FETCH;
            if (miss_cnt_q != 16'hFFFF) begin
              miss_cnt_q <= miss_cnt_q + 16'd1;
            end
          end
        end
        FETCH: begin
          if (MEM_VALID) begin
            data_q[fill_index]  <= MEM_READDATA;
            tag_q[fill_index]   <= maddr_q[ADDR_BITS-5:INDEX_BITS];
            valid_q[fill_index] <= 1'b1;
            state_q             <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
